// File: rtl/trng_sample_ctrl.sv
// ---------------------------------------------------------------------------
// trng_sample_ctrl
//
// Sequencing controller for an RS-latch entropy cell. The cell is powered up
// and allowed to settle for a fixed number of cycles. Its output is then
// sampled in pairs through a two-flop synchronizer. A von Neumann corrector
// debiases the pairs, and the accepted bits are packed MSB-first into bytes
// that leave over a valid/ready handshake. A repetition-count health test
// watches the raw stream and latches a sticky failure that shuts the cell off.
//
// Parameters
//   SETTLE_CYCLES  cycles src_en is high before the first sample (1..255)
//   RCT_LIMIT      identical consecutive raw samples that trip the test (2..255)
//
// Ports
//   clk          in   system clock, all state on the rising edge
//   rst_n        in   asynchronous active-low reset
//   enable       in   level-sensitive run request
//   raw_bit      in   entropy cell output, asynchronous to clk
//   src_en       out  enable to the entropy cell
//   byte_out     out  assembled random byte (meaningful while byte_valid)
//   byte_valid   out  byte_out holds a complete byte
//   byte_ready   in   consumer accepts the byte
//   health_fail  out  sticky repetition-count failure
//   busy         out  controller is not idle
// ---------------------------------------------------------------------------
module trng_sample_ctrl #(
    parameter int SETTLE_CYCLES = 4,
    parameter int RCT_LIMIT     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       raw_bit,
    output logic       src_en,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       health_fail,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMP_A,
        S_SAMP_B,
        S_OUTPUT,
        S_FAIL
    } state_t;

    localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);
    localparam logic [7:0] RCT_MAX     = 8'(RCT_LIMIT);

    // Synchronizer flops; r_sync2 is the only copy of the cell output used.
    logic       r_sync1;
    logic       r_sync2;

    state_t     r_state;
    state_t     w_nextState;

    logic [7:0] r_settleCnt;
    logic [3:0] r_bitCnt;
    logic       r_sampA;
    logic       r_prevRaw;
    logic [7:0] r_rctCnt;
    logic [7:0] r_byte;

    logic       r_srcEn;
    logic       r_byteValid;
    logic       r_healthFail;
    logic       r_busy;

    logic       w_sampling;
    logic [7:0] w_rctNext;
    logic       w_rctTrip;
    logic       w_pairValid;

    // Bring the asynchronous cell output into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw_bit;
            r_sync2 <= r_sync1;
        end
    end

    // Repetition-count bookkeeping for the sample taken this cycle. The
    // counter never passes RCT_LIMIT because reaching it leaves the sampling
    // states, so the increment cannot wrap.
    assign w_sampling  = (r_state == S_SAMP_A) || (r_state == S_SAMP_B);
    assign w_rctNext   = (r_sync2 == r_prevRaw) ? (r_rctCnt + 8'd1) : 8'd1;
    assign w_rctTrip   = w_sampling && (w_rctNext == RCT_MAX);

    // Von Neumann: a pair is kept only when its two samples differ, and the
    // kept bit is the first sample of the pair (10 -> 1, 01 -> 0).
    assign w_pairValid = (r_state == S_SAMP_B) && (r_sampA != r_sync2);

    // Next-state decision. A health trip outranks everything else in the
    // sampling states; a dropped enable is honoured immediately except in
    // OUTPUT, where the pending byte must be handed off first.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable)
                    w_nextState = S_SETTLE;
            end
            S_SETTLE: begin
                if (!enable)
                    w_nextState = S_IDLE;
                else if (r_settleCnt == 8'd1)
                    w_nextState = S_SAMP_A;
            end
            S_SAMP_A: begin
                if (w_rctTrip)
                    w_nextState = S_FAIL;
                else if (!enable)
                    w_nextState = S_IDLE;
                else
                    w_nextState = S_SAMP_B;
            end
            S_SAMP_B: begin
                if (w_rctTrip)
                    w_nextState = S_FAIL;
                else if (!enable)
                    w_nextState = S_IDLE;
                else if (w_pairValid && (r_bitCnt == 4'd7))
                    w_nextState = S_OUTPUT;
                else
                    w_nextState = S_SAMP_A;
            end
            S_OUTPUT: begin
                // byte_valid is always high here, so ready alone completes it.
                if (byte_ready)
                    w_nextState = enable ? S_SAMP_A : S_IDLE;
            end
            S_FAIL: begin
                if (!enable)
                    w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // State register, registered outputs decoded from the upcoming state, and
    // the datapath registers that each state owns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_settleCnt  <= 8'd0;
            r_bitCnt     <= 4'd0;
            r_sampA      <= 1'b0;
            r_prevRaw    <= 1'b0;
            r_rctCnt     <= 8'd0;
            r_byte       <= 8'h00;
            r_srcEn      <= 1'b0;
            r_byteValid  <= 1'b0;
            r_healthFail <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_srcEn      <= (w_nextState == S_SETTLE) || (w_nextState == S_SAMP_A) ||
                            (w_nextState == S_SAMP_B) || (w_nextState == S_OUTPUT);
            r_byteValid  <= (w_nextState == S_OUTPUT);
            r_healthFail <= (w_nextState == S_FAIL);
            r_busy       <= (w_nextState != S_IDLE);

            case (r_state)
                S_IDLE: begin
                    r_rctCnt  <= 8'd0;
                    r_prevRaw <= 1'b0;
                    r_bitCnt  <= 4'd0;
                    if (enable)
                        r_settleCnt <= SETTLE_INIT;
                end
                S_SETTLE: begin
                    r_settleCnt <= r_settleCnt - 8'd1;
                end
                S_SAMP_A: begin
                    r_sampA   <= r_sync2;
                    r_prevRaw <= r_sync2;
                    r_rctCnt  <= w_rctNext;
                end
                S_SAMP_B: begin
                    r_prevRaw <= r_sync2;
                    r_rctCnt  <= w_rctNext;
                    if (w_pairValid && !w_rctTrip && enable) begin
                        r_byte   <= {r_byte[6:0], r_sampA};
                        r_bitCnt <= r_bitCnt + 4'd1;
                    end
                end
                S_OUTPUT: begin
                    if (byte_ready)
                        r_bitCnt <= 4'd0;
                end
                default: begin
                end
            endcase

            // Any exit to IDLE or FAIL throws away a partially built byte.
            if ((w_nextState == S_IDLE) || (w_nextState == S_FAIL))
                r_bitCnt <= 4'd0;
        end
    end

    assign src_en      = r_srcEn;
    assign byte_out    = r_byte;
    assign byte_valid  = r_byteValid;
    assign health_fail = r_healthFail;
    assign busy        = r_busy;

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trng_sample_ctrl
//
// Directed bench for trng_sample_ctrl with default parameters. Each scenario
// starts from IDLE with enable rising at a clock edge numbered 0. The wanted
// synchronized value at edge k is placed in sched[k]; because the
// synchronizer is two flops deep, raw_bit is driven with sched[k+2] just
// before edge k. Outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_trng_sample_ctrl;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       raw_bit;
    logic       src_en;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       health_fail;
    logic       busy;

    int checks;
    int errors;

    logic sched [0:127];

    trng_sample_ctrl #(
        .SETTLE_CYCLES(4),
        .RCT_LIMIT    (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .raw_bit    (raw_bit),
        .src_en     (src_en),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .health_fail(health_fail),
        .busy       (busy)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearSched();
        for (int i = 0; i < 128; i++)
            sched[i] = 1'b0;
    endtask

    // Pair n occupies edges 5+2n (first sample) and 6+2n (second sample).
    task automatic setPair(input int n, input logic a, input logic b);
        sched[5 + 2 * n] = a;
        sched[6 + 2 * n] = b;
    endtask

    task automatic goIdle();
        enable     = 1'b0;
        byte_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        enable     = 1'b0;
        raw_bit    = 1'b0;
        byte_ready = 1'b1;
        #12;
        checks++;
        if (src_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_src_en: got %0b expected 0", src_en);
        end
        checks++;
        if (byte_out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_byte_out: got %0h expected 00", byte_out);
        end
        checks++;
        if ({byte_valid, health_fail, busy} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 000", {byte_valid, health_fail, busy});
        end
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_pattern_f0();
        clearSched();
        for (int p = 0; p < 4; p++) setPair(p, 1'b1, 1'b0);
        for (int p = 4; p < 8; p++) setPair(p, 1'b0, 1'b1);
        byte_ready = 1'b1;
        enable     = 1'b1;
        for (int j = 0; j <= 20; j++) begin
            raw_bit = sched[j + 2];
            tick();
            if (j == 19) begin
                checks++;
                if (byte_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL f0_early_valid: got %0b expected 0", byte_valid);
                end
            end
            if (j == 20) begin
                checks++;
                if (byte_valid !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL f0_valid: got %0b expected 1", byte_valid);
                end
                checks++;
                if (byte_out !== 8'hF0) begin
                    errors++;
                    $display("[TB] FAIL f0_byte: got %0h expected f0", byte_out);
                end
            end
        end
        goIdle();
    endtask

    task automatic test_zero_byte();
        clearSched();
        for (int p = 0; p < 12; p++) setPair(p, 1'b0, 1'b1);
        byte_ready = 1'b1;
        checks++;
        if (src_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_idle_src_en: got %0b expected 0", src_en);
        end
        enable = 1'b1;
        for (int j = 0; j <= 21; j++) begin
            raw_bit = sched[j + 2];
            tick();
            if (j <= 4) begin
                checks++;
                if (src_en !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL zero_settle_src_en_e%0d: got %0b expected 1", j, src_en);
                end
            end
            if (j >= 16) begin
                checks++;
                if (byte_valid !== (j == 20)) begin
                    errors++;
                    $display("[TB] FAIL zero_valid_e%0d: got %0b expected %0b", j, byte_valid, (j == 20));
                end
            end
            if (j == 20) begin
                checks++;
                if (byte_out !== 8'h00) begin
                    errors++;
                    $display("[TB] FAIL zero_byte: got %0h expected 00", byte_out);
                end
            end
            if (j == 21) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL zero_continue_busy: got %0b expected 1", busy);
                end
            end
        end
        goIdle();
    endtask

    task automatic test_discard_pairs();
        clearSched();
        for (int q = 0; q < 4; q++) begin
            setPair(4 * q,     1'b1, 1'b0);
            setPair(4 * q + 1, 1'b0, 1'b0);
            setPair(4 * q + 2, 1'b0, 1'b1);
            setPair(4 * q + 3, 1'b1, 1'b1);
        end
        byte_ready = 1'b1;
        enable     = 1'b1;
        for (int j = 0; j <= 34; j++) begin
            raw_bit = sched[j + 2];
            tick();
            if (j == 33) begin
                checks++;
                if (byte_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL aa_early_valid: got %0b expected 0", byte_valid);
                end
            end
            if (j == 34) begin
                checks++;
                if (byte_valid !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL aa_valid: got %0b expected 1", byte_valid);
                end
                checks++;
                if (byte_out !== 8'hAA) begin
                    errors++;
                    $display("[TB] FAIL aa_byte: got %0h expected aa", byte_out);
                end
            end
        end
        goIdle();
    endtask

    task automatic test_health_fail();
        clearSched();
        for (int k = 5; k < 60; k++) sched[k] = 1'b1;
        byte_ready = 1'b1;
        enable     = 1'b1;
        for (int j = 0; j <= 22; j++) begin
            raw_bit = sched[j + 2];
            tick();
            if (j == 19) begin
                checks++;
                if ({health_fail, src_en} !== 2'b01) begin
                    errors++;
                    $display("[TB] FAIL rct_before: got hf,src=%b expected 01", {health_fail, src_en});
                end
            end
            if (j == 20) begin
                checks++;
                if (health_fail !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL rct_trip: got %0b expected 1", health_fail);
                end
                checks++;
                if (src_en !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL rct_src_off: got %0b expected 0", src_en);
                end
            end
            if (j >= 5) begin
                checks++;
                if (byte_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL rct_no_valid_e%0d: got %0b expected 0", j, byte_valid);
                end
            end
            if (j == 22) begin
                checks++;
                if (health_fail !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL rct_sticky: got %0b expected 1", health_fail);
                end
            end
        end
        enable = 1'b0;
        tick();
        checks++;
        if ({health_fail, busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL rct_clear: got hf,busy=%b expected 00", {health_fail, busy});
        end
        goIdle();
    endtask

    task automatic test_backpressure();
        clearSched();
        setPair(0, 1'b1, 1'b0);
        setPair(1, 1'b1, 1'b0);
        setPair(2, 1'b0, 1'b1);
        setPair(3, 1'b0, 1'b1);
        setPair(4, 1'b0, 1'b1);
        setPair(5, 1'b0, 1'b1);
        setPair(6, 1'b1, 1'b0);
        setPair(7, 1'b1, 1'b0);
        byte_ready = 1'b0;
        enable     = 1'b1;
        for (int j = 0; j <= 20; j++) begin
            raw_bit = sched[j + 2];
            tick();
        end
        checks++;
        if ({byte_valid, byte_out} !== {1'b1, 8'hC3}) begin
            errors++;
            $display("[TB] FAIL bp_first: got valid=%0b byte=%0h expected valid=1 byte=c3", byte_valid, byte_out);
        end
        for (int k = 1; k <= 10; k++) begin
            if (k == 2) enable = 1'b0;
            tick();
            checks++;
            if ({byte_valid, byte_out} !== {1'b1, 8'hC3}) begin
                errors++;
                $display("[TB] FAIL bp_hold_%0d: got valid=%0b byte=%0h expected valid=1 byte=c3", k, byte_valid, byte_out);
            end
        end
        byte_ready = 1'b1;
        tick();
        checks++;
        if ({byte_valid, busy, src_en} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL bp_release: got valid,busy,src=%b expected 000", {byte_valid, busy, src_en});
        end
        goIdle();
    endtask

    task automatic test_enable_drop();
        clearSched();
        for (int p = 0; p < 5; p++) setPair(p, 1'b1, 1'b0);
        byte_ready = 1'b1;
        enable     = 1'b1;
        for (int j = 0; j <= 14; j++) begin
            raw_bit = sched[j + 2];
            tick();
        end
        enable = 1'b0;
        tick();
        checks++;
        if ({busy, src_en, byte_valid} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL drop_idle: got busy,src,valid=%b expected 000", {busy, src_en, byte_valid});
        end
        tick();
        clearSched();
        for (int p = 0; p < 8; p++) setPair(p, 1'b0, 1'b1);
        enable = 1'b1;
        for (int j = 0; j <= 20; j++) begin
            raw_bit = sched[j + 2];
            tick();
            if (j == 2) begin
                checks++;
                if ({src_en, busy} !== 2'b11) begin
                    errors++;
                    $display("[TB] FAIL drop_resettle: got src,busy=%b expected 11", {src_en, busy});
                end
            end
            if (j >= 5 && j <= 19) begin
                checks++;
                if (byte_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL drop_stale_valid_e%0d: got %0b expected 0", j, byte_valid);
                end
            end
            if (j == 20) begin
                checks++;
                if ({byte_valid, byte_out} !== {1'b1, 8'h00}) begin
                    errors++;
                    $display("[TB] FAIL drop_new_byte: got valid=%0b byte=%0h expected valid=1 byte=00", byte_valid, byte_out);
                end
            end
        end
        goIdle();
    endtask

    task automatic test_async_reset();
        clearSched();
        for (int p = 0; p < 4; p++) setPair(p, 1'b1, 1'b0);
        for (int p = 4; p < 8; p++) setPair(p, 1'b0, 1'b1);
        byte_ready = 1'b1;
        enable     = 1'b1;
        for (int j = 0; j <= 22; j++) begin
            raw_bit = sched[j + 2];
            tick();
        end
        checks++;
        if ({busy, byte_out} !== {1'b1, 8'hF0}) begin
            errors++;
            $display("[TB] FAIL arst_before: got busy=%0b byte=%0h expected busy=1 byte=f0", busy, byte_out);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (byte_out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL arst_byte: got %0h expected 00", byte_out);
        end
        checks++;
        if ({src_en, byte_valid, health_fail, busy} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL arst_flags: got %b expected 0000", {src_en, byte_valid, health_fail, busy});
        end
        enable = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL arst_after: got busy=%0b expected 0", busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clearSched();
        test_reset();
        test_pattern_f0();
        test_zero_byte();
        test_discard_pairs();
        test_health_fail();
        test_backpressure();
        test_enable_drop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trng_sample_ctrl.md
# trng_sample_ctrl

Sequencing controller for the RS-latch entropy cell. It powers the cell up and waits a fixed settle time, then samples the cell's asynchronous output through a synchronizer. Raw bits are debiased with a von Neumann corrector and packed into bytes, which are handed off over a valid/ready interface. A repetition-count health test runs on the raw stream and latches a failure flag that stops the source.

## Interface

- `SETTLE_CYCLES`, default 4: cycles `src_en` is held high before the first sample; legal range 1..255.
- `RCT_LIMIT`, default 16: number of consecutive identical raw samples that trips the health test; legal range 2..255.

- `clk`  in  1  single system clock; all state on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run request, level-sensitive.
- `raw_bit`  in  1  entropy cell output, asynchronous to `clk`.
- `src_en`  out  1  enable to the entropy cell.
- `byte_out`  out  8  assembled random byte.
- `byte_valid`  out  1  `byte_out` holds a complete byte.
- `byte_ready`  in  1  consumer accepts the byte.
- `health_fail`  out  1  sticky repetition-count failure.
- `busy`  out  1  high whenever state is not IDLE.

## Operation

- Reset values: state IDLE; `src_en`=0; `byte_out`=0x00; `byte_valid`=0; `health_fail`=0; `busy`=0; bit count, settle counter and repetition counter all 0.
- Synchronizer: two flops on `raw_bit`. The synced value `rs` is the only value sampled.
- State machine (IDLE, SETTLE, SAMP_A, SAMP_B, OUTPUT, FAIL):
  - IDLE: `src_en`=0. When `enable`=1, load the settle counter with `SETTLE_CYCLES` and go to SETTLE.
  - SETTLE: `src_en`=1. Decrement the counter each cycle. Go to SAMP_A on the cycle the counter reads 1.
  - SAMP_A: capture `rs` into `a`, then go to SAMP_B.
  - SAMP_B: capture `rs` as `b`, then evaluate the pair:
    - (0,1) shifts in 0; (1,0) shifts in 1; (0,0) and (1,1) are discarded.
    - Shift rule: `byte_out` <= {`byte_out`[6:0], bit}, so the first accepted bit ends in bit 7.
    - If this was the 8th accepted bit, go to OUTPUT; otherwise return to SAMP_A.
  - OUTPUT: `byte_valid`=1, `src_en`=1, `byte_out` frozen, no sampling.
    - On `byte_valid` & `byte_ready`: clear the bit count, then go to SAMP_A if `enable`=1, else IDLE.
  - FAIL: `src_en`=0, `byte_valid`=0, `health_fail`=1. Stay until `enable`=0, then go to IDLE and clear `health_fail`.
- Repetition-count test: applies to every raw sample taken in SAMP_A or SAMP_B.
  - If the sample equals the previous raw sample, increment the counter; otherwise set it to 1.
  - When the counter reaches `RCT_LIMIT`, go to FAIL on the next edge. This overrides the pair result, and the partial byte is discarded.
  - The counter and previous-sample register are cleared in IDLE only, so they persist across OUTPUT.
- `enable` deasserted:
  - In SETTLE, SAMP_A or SAMP_B: go to IDLE on the next edge, discarding the partial byte and clearing the bit count.
  - In OUTPUT: `byte_valid` must not drop. Complete the handshake first, then go to IDLE.
- `byte_out` keeps its last value outside OUTPUT. It is valid only while `byte_valid`=1.

## Timing

- `raw_bit` to sample point: 2 cycles of synchronizer latency.
- `enable` rising at edge 0:
  - SETTLE runs from edge 1 to edge `SETTLE_CYCLES`.
  - The first SAMP_A is at edge `SETTLE_CYCLES`+1.
- Each raw pair takes 2 cycles. The minimum time per byte is 16 sampling cycles.
- `byte_valid` rises on the edge after the SAMP_B that produced the 8th bit.
- Handshake: transfer occurs on any edge where `byte_valid` & `byte_ready`. `byte_ready` may be held high permanently, giving zero stall. SAMP_A follows the transfer edge directly.
- Fastest continuous rate: one byte per 17 cycles (16 sample cycles plus 1 OUTPUT cycle).
- `health_fail` rises 1 cycle after the sample that reached `RCT_LIMIT`. `src_en` falls in the same cycle.
- Asynchronous reset mid-operation: all outputs take their reset values immediately, including a pending byte, which is dropped.

## Test plan

- Defaults; `enable`=1; synced raw stream 0,1 repeated; `byte_ready`=1 → `src_en` high for 4 cycles before the first sample, then `byte_out`=0x00 with `byte_valid` high for 1 cycle, 16 cycles after sampling starts.
- Synced pairs 1,0 ×4 then 0,1 ×4 → `byte_out`=0xF0. `byte_valid` asserts after exactly 8 accepted pairs.
- Pairs 0,0 and 1,1 interleaved with 0,1/1,0, with no run of 16 identical raw samples → discarded pairs add nothing. Pairs 1,0 / 0,1 alternating ×4 give 0xAA.
- `RCT_LIMIT`=16, raw held at 1 → `health_fail`=1 and `src_en`=0 one cycle after the 16th sample, with no `byte_valid`. Drop `enable` → IDLE and `health_fail`=0.
- `byte_ready`=0 for 10 cycles with `byte_valid`=1, and `enable` dropped meanwhile → `byte_out` stable, `byte_valid` held. On `byte_ready`=1: one transfer, then IDLE and `busy`=0.
- Drop `enable` after 5 accepted bits, then re-enable → settle repeats and the next byte contains only new bits. Pulse `rst_n` low during SAMP_B → all outputs return to reset values immediately.
